// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin two-port arbiter and zero-fill sequencer for a single-port data memory
module dmem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_DEPTH = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_strm
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(MEM_DEPTH - 1);

    state_t              state_q, state_d;
    logic                rr_q, rr_d;           // 1: p1 is favoured on contention
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                p0_rvalid_q, p0_rvalid_d;
    logic                p1_rvalid_q, p1_rvalid_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;

    logic                win0, win1;
    logic                sel_we, sel_oor;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    // Pick a winner; grants are suppressed during reset and while clearing
    always_comb begin
        win0 = 1'b0;
        win1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            if (p0_req && (!p1_req || !rr_q)) begin
                win0 = 1'b1;
            end else if (p1_req) begin
                win1 = 1'b1;
            end
        end
        sel_we    = win1 ? p1_we    : p0_we;
        sel_addr  = win1 ? p1_addr  : p0_addr;
        sel_wdata = win1 ? p1_wdata : p0_wdata;
        sel_oor   = (sel_addr >= DEPTH_A);
    end

    // Memory drive: clear sweep, winner access, or quiet bus
    always_comb begin
        mem_we   = 1'b0;
        mem_re   = 1'b0;
        mem_addr = '0;
        mem_data = '0;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we   = 1'b1;
                mem_addr = cnt_q;
            end else if (win0 || win1) begin
                mem_addr = sel_addr;
                mem_data = sel_wdata;
                mem_we   = sel_we & ~sel_oor;
                mem_re   = ~sel_we & ~sel_oor;
            end
        end
    end

    // Next-state: pointer, read capture, clear sequencing
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        p0_rvalid_d = 1'b0;
        p1_rvalid_d = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        if (win0) begin
            rr_d = 1'b1;
            if (!p0_we) begin
                p0_rvalid_d = 1'b1;
                p0_rdata_d  = sel_oor ? '0 : mem_strm;
            end
        end
        if (win1) begin
            rr_d = 1'b0;
            if (!p1_we) begin
                p1_rvalid_d = 1'b1;
                p1_rdata_d  = sel_oor ? '0 : mem_strm;
            end
        end
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (clr_start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (cnt_q == LAST_A) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            p0_rvalid_q <= p0_rvalid_d;
            p1_rvalid_q <= p1_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_gnt    = win0;
    assign p1_gnt    = win1;
    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign clr_busy  = (state_q == CLEAR);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit data memory between two requesters: port 0 is the CPU load/store stage and port 1 is the debug/DMA loader.
- Arbitrates round-robin and drives the memory's data, address, write-enable and read-enable inputs.
- Registers read data back to the winning requester.
- Contains a clear sequencer that zero-fills the whole memory on command, without asserting the memory's own reset.

Parameters:
- DATA_W, 16, data width of requesters and memory.
- ADDR_W, 16, address width of requesters and memory.
- MEM_DEPTH, 128, number of valid memory words; addresses >= MEM_DEPTH are out of range.

Ports:
- clk  in  1  system clock, all state on posedge.
- rst  in  1  synchronous, active-high reset.
- p0_req  in  1  port 0 access request.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 word address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_gnt  out  1  port 0 access accepted this cycle.
- p0_rvalid  out  1  port 0 read data valid.
- p0_rdata  out  DATA_W  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- clr_start  in  1  pulse: begin zero-fill of memory.
- clr_busy  out  1  zero-fill in progress.
- mem_data  out  DATA_W  to memory write data.
- mem_addr  out  ADDR_W  to memory address.
- mem_we  out  1  to memory write enable.
- mem_re  out  1  to memory read enable.
- mem_strm  in  DATA_W  from memory combinational read data.

Behaviour:
- FSM has two states, IDLE and CLEAR; reset enters IDLE.
- Reset values:
  - gnt, rvalid and clr_busy are 0.
  - rdata is 0.
  - mem_we and mem_re are 0; mem_addr and mem_data are 0.
  - Round-robin pointer favours p0; clear counter is 0.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high in the same cycle.
  - gnt is combinational from req and the arbitration state.
  - At most one gnt is high per cycle; gnt is never high without the matching req.
- Arbitration in IDLE:
  - If only one port requests, that port wins.
  - If both request, the port not granted most recently wins.
  - The pointer updates only on a grant.
  - First contention after reset goes to p0.
- Memory drive in IDLE with a winner:
  - mem_addr = winner addr; mem_data = winner wdata.
  - mem_we = winner we; mem_re = ~winner we.
- Memory drive in IDLE with no winner: mem_we = 0, mem_re = 0; mem_addr and mem_data hold 0.
- Write latency: memory updates at the posedge that ends the grant cycle.
- Read latency: 1 cycle.
  - rdata is captured from mem_strm at the grant-cycle posedge.
  - rvalid pulses high for exactly one cycle, on the granted port only.
  - The other port's rdata holds its last value.
- Back-to-back grants to the same port are allowed every cycle, giving full throughput.
- Out-of-range address (addr >= MEM_DEPTH):
  - The request is still granted so the requester never hangs.
  - mem_we and mem_re are forced to 0.
  - A read returns rdata = 0 with rvalid = 1.
- Clear start:
  - clr_start sampled high in IDLE moves the FSM to CLEAR on the next cycle.
  - A request granted in the same cycle as clr_start completes normally.
- CLEAR state:
  - clr_busy = 1; p0_gnt and p1_gnt are forced 0.
  - Each cycle drives mem_we = 1, mem_re = 0, mem_addr = counter, mem_data = 0, then increments the counter.
  - After address MEM_DEPTH-1 is written, the FSM returns to IDLE and the counter resets to 0.
  - clr_busy is high for exactly MEM_DEPTH cycles.
- clr_start while in CLEAR is ignored; the clear does not restart.
- Pending requests stall during CLEAR. After CLEAR, arbitration resumes with the pointer preserved.
- rst asserted at any point, including mid-CLEAR or mid-read:
  - Next cycle is IDLE with reset values.
  - The partially cleared memory is left as-is.
  - No rvalid is issued for a read whose grant cycle coincided with rst.

Test Plan:
- Single-port traffic: p0 writes 0xBEEF to addr 5, then reads addr 5 -> p0_gnt high in each request cycle; p0_rvalid high one cycle after the read grant with p0_rdata = 0xBEEF; p1 outputs stay 0.
- Contention: p0 and p1 both hold read requests for 4 cycles -> grants alternate p0, p1, p0, p1; p1 writes 0x1234 to addr 7 while p0 reads addr 7 in the next granted cycle -> p0_rdata = 0x1234.
- Out of range: p1 writes 0xFFFF to addr 200, then reads addr 200 -> both granted; mem_we = 0 on the write; p1_rvalid = 1 with p1_rdata = 0; the memory contents dump is unchanged.
- Clear: fill addrs 0..127 with nonzero data, pulse clr_start with p0_req held -> clr_busy high for 128 cycles; p0_gnt = 0 during clr_busy; p0 is granted on the first cycle after clr_busy falls; reads of addrs 0, 64 and 127 return 0.
- Clear edge cases: second clr_start at busy cycle 10 -> busy still ends 128 cycles after the first start. Separately, assert rst at busy cycle 50 -> clr_busy = 0 next cycle, addrs 0..49 read 0 and addr 60 retains its data.
- Reset: assert rst for 2 cycles during active read traffic -> all gnt/rvalid/rdata/mem_* outputs are 0; first post-reset contention grants p0.
